// File: rtl/conv_seq_pkg.sv
// Shared types for the convolution layer sequencer: descriptor layout, FSM states,
// indices of the derived Img2Col configuration values.
package conv_seq_pkg;

  localparam int MAX_LAYERS_DEFAULT = 16;
  localparam int DESC_W             = 53;

  localparam int IN_SIZE_LSB = 0;
  localparam int IN_SIZE_W   = 12;
  localparam int IN_CH_LSB   = 12;
  localparam int IN_CH_W     = 12;
  localparam int OUT_CH_LSB  = 24;
  localparam int OUT_CH_W    = 12;
  localparam int KERNEL_LSB  = 36;
  localparam int KERNEL_W    = 5;
  localparam int STRIDE_LSB  = 41;
  localparam int STRIDE_W    = 3;
  localparam int WINDOW_LSB  = 44;
  localparam int WINDOW_W    = 8;
  localparam int M2I_BIT     = 52;

  typedef struct packed {
    logic                 matrix2img;
    logic [WINDOW_W-1:0]  window;
    logic [STRIDE_W-1:0]  stride_log2;
    logic [KERNEL_W-1:0]  kernel;
    logic [OUT_CH_W-1:0]  out_ch;
    logic [IN_CH_W-1:0]   in_ch;
    logic [IN_SIZE_W-1:0] in_size;
  } desc_t;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_DERIVE1, S_DERIVE2, S_START, S_RUN, S_NEXT, S_DONE
  } seq_state_t;

  typedef enum logic [3:0] {
    I2C_STRIDE, I2C_KERNEL, I2C_WINDOW, I2C_IN_SIZE, I2C_IN_CH, I2C_OUT_CH, I2C_OUT_SIZE,
    I2C_SLIDE, I2C_OUTCOL_T, I2C_INCOL_T, I2C_OUTROW_T, I2C_OUTCH_T, I2C_WROW
  } i2c_idx_t;

  localparam int I2C_N = 13;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/conv_cfg_derive.sv
// Two-stage pipeline turning one layer descriptor into the Img2Col configuration set
// plus a single configuration-error flag; results are valid two cycles after desc.
module conv_cfg_derive
  import conv_seq_pkg::*;
#(
  parameter int OUT_W      = 16,
  parameter int SLIDE_LOG2 = 3
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  desc_t                       desc,
  output logic [I2C_N-1:0][OUT_W-1:0] vals,
  output logic                        cfg_err
);

  desc_t                s1_desc;
  logic [IN_SIZE_W-1:0] s1_diff;
  logic [23:0]          s1_area;
  logic [9:0]           s1_kk;
  logic                 s1_err;

  // NOTE: flops are written with <= so each one samples pre-edge values no matter the statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_desc <= '0;
      s1_diff <= '0;
      s1_area <= '0;
      s1_kk   <= '0;
      s1_err  <= 1'b0;
    end else begin
      s1_desc <= desc;
      s1_diff <= desc.in_size - IN_SIZE_W'(desc.kernel);
      s1_area <= 24'(desc.in_size) * 24'(desc.in_ch);
      s1_kk   <= 10'(desc.kernel) * 10'(desc.kernel);
      s1_err  <= (desc.kernel == '0) || (IN_SIZE_W'(desc.kernel) > desc.in_size) ||
                 (desc.in_ch[2:0] != '0) || (desc.out_ch[2:0] != '0);
    end
  end

  logic [I2C_N-1:0][31:0] wide;
  logic [31:0]            out_size;
  logic                   ovf;

  // NOTE: every variable gets a default at the top so no path can infer a latch.
  always_comb begin
    wide     = '0;
    ovf      = 1'b0;
    out_size = 32'(s1_diff >> s1_desc.stride_log2) + 32'd1;
    wide[I2C_STRIDE]   = 32'd1 << s1_desc.stride_log2;
    wide[I2C_KERNEL]   = 32'(s1_desc.kernel);
    wide[I2C_WINDOW]   = 32'(s1_desc.window);
    wide[I2C_IN_SIZE]  = 32'(s1_desc.in_size);
    wide[I2C_IN_CH]    = 32'(s1_desc.in_ch);
    wide[I2C_OUT_CH]   = 32'(s1_desc.out_ch);
    wide[I2C_OUT_SIZE] = out_size;
    wide[I2C_SLIDE]    = 32'd1 << SLIDE_LOG2;
    wide[I2C_OUTCOL_T] = (out_size + 32'd7) >> 3;
    wide[I2C_INCOL_T]  = 32'(s1_area >> 3);
    wide[I2C_OUTROW_T] = out_size;
    wide[I2C_OUTCH_T]  = 32'(s1_desc.out_ch >> 3);
    wide[I2C_WROW]     = 32'(s1_kk) * 32'(s1_desc.in_ch);
    for (int i = 0; i < I2C_N; i++) ovf |= ((wide[i] >> OUT_W) != '0);
  end

  logic unused_m2i;
  assign unused_m2i = s1_desc.matrix2img;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vals    <= '0;
      cfg_err <= 1'b0;
    end else begin
      for (int i = 0; i < I2C_N; i++) vals[i] <= wide[i][OUT_W-1:0];
      cfg_err <= s1_err | ovf;
    end
  end

endmodule

// File: rtl/conv_layer_sequencer.sv
// Steps the convolution unit through a table of layer descriptors without host help.
// Define SEQ_PERF_CNT_EN to build the per-layer cycle counter behind perf_cycles.
module conv_layer_sequencer
  import conv_seq_pkg::*;
#(
  parameter int MAX_LAYERS = MAX_LAYERS_DEFAULT,
  parameter int SLIDE_LOG2 = 3,
  parameter int OUT_W      = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          cfg_we,
  input  logic [$clog2(MAX_LAYERS)-1:0] cfg_addr,
  input  logic [63:0]                   cfg_wdata,
  input  logic [$clog2(MAX_LAYERS):0]   layer_count,
  input  logic                          seq_start,
  input  logic                          seq_abort,
  input  logic                          conv_last,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [$clog2(MAX_LAYERS)-1:0] err_layer,
  output logic [$clog2(MAX_LAYERS)-1:0] cur_layer,
  output logic                          conv_start,
  output logic                          conv_switch,
  output logic                          conv_matrix2img,
  output logic [OUT_W-1:0]              i2c_stride,
  output logic [OUT_W-1:0]              i2c_kernel,
  output logic [OUT_W-1:0]              i2c_window,
  output logic [OUT_W-1:0]              i2c_in_size,
  output logic [OUT_W-1:0]              i2c_in_ch,
  output logic [OUT_W-1:0]              i2c_out_ch,
  output logic [OUT_W-1:0]              i2c_out_size,
  output logic [OUT_W-1:0]              i2c_slide,
  output logic [OUT_W-1:0]              i2c_outcol_t,
  output logic [OUT_W-1:0]              i2c_incol_t,
  output logic [OUT_W-1:0]              i2c_outrow_t,
  output logic [OUT_W-1:0]              i2c_outch_t,
  output logic [OUT_W-1:0]              i2c_wrow,
  output logic [31:0]                   perf_cycles
);

  localparam int            AW      = $clog2(MAX_LAYERS);
  localparam logic [AW:0]   MAX_CNT = MAX_LAYERS[AW:0];

  seq_state_t                  state;
  desc_t                       desc_q;
  logic [AW:0]                 count_q;
  logic [AW:0]                 next_idx;
  logic [I2C_N-1:0][OUT_W-1:0] derived;
  logic [I2C_N-1:0][OUT_W-1:0] i2c_q;
  logic                        cfg_err;
  logic [DESC_W-1:0]           desc_mem [MAX_LAYERS];

  logic unused_wdata;
  assign unused_wdata = |cfg_wdata[63:DESC_W];

  // NOTE: the table is deliberately not reset; entries are meaningful only after the host writes them.
  always_ff @(posedge clk) begin
    if (cfg_we && !busy) desc_mem[cfg_addr] <= cfg_wdata[DESC_W-1:0];
  end

  conv_cfg_derive #(.OUT_W(OUT_W), .SLIDE_LOG2(SLIDE_LOG2)) u_derive (
    .clk     (clk),
    .reset_n (reset_n),
    .desc    (desc_q),
    .vals    (derived),
    .cfg_err (cfg_err)
  );

  assign next_idx = {1'b0, cur_layer} + {{AW{1'b0}}, 1'b1};

  // Outputs are registered alongside the state; conv_start rises with the first RUN cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= S_IDLE;
      desc_q          <= '0;
      count_q         <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      err             <= 1'b0;
      err_layer       <= '0;
      cur_layer       <= '0;
      conv_start      <= 1'b0;
      conv_switch     <= 1'b0;
      conv_matrix2img <= 1'b0;
      i2c_q           <= '0;
    end else begin
      conv_start <= 1'b0;
      done       <= 1'b0;
      if (seq_abort) begin
        state           <= S_IDLE;
        busy            <= 1'b0;
        conv_switch     <= 1'b0;
        conv_matrix2img <= 1'b0;
        i2c_q           <= '0;
      end else begin
        case (state)
          S_IDLE: if (seq_start) begin
            err         <= 1'b0;
            cur_layer   <= '0;
            count_q     <= (layer_count > MAX_CNT) ? MAX_CNT : layer_count;
            busy        <= 1'b1;
            conv_switch <= 1'b1;
            if (layer_count == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_LOAD;
            end
          end
          S_LOAD: begin
            desc_q <= desc_t'(desc_mem[cur_layer]);
            state  <= S_DERIVE1;
          end
          S_DERIVE1: state <= S_DERIVE2;
          S_DERIVE2: state <= S_START;
          S_START: if (cfg_err) begin
            err       <= 1'b1;
            err_layer <= cur_layer;
            done      <= 1'b1;
            state     <= S_DONE;
          end else begin
            conv_start      <= 1'b1;
            i2c_q           <= derived;
            conv_matrix2img <= desc_q.matrix2img;
            state           <= S_RUN;
          end
          S_RUN: if (conv_last) state <= S_NEXT;
          S_NEXT: if (next_idx < count_q) begin
            cur_layer <= next_idx[AW-1:0];
            state     <= S_LOAD;
          end else begin
            done  <= 1'b1;
            state <= S_DONE;
          end
          S_DONE: begin
            state           <= S_IDLE;
            busy            <= 1'b0;
            conv_switch     <= 1'b0;
            conv_matrix2img <= 1'b0;
            i2c_q           <= '0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign i2c_stride   = i2c_q[I2C_STRIDE];
  assign i2c_kernel   = i2c_q[I2C_KERNEL];
  assign i2c_window   = i2c_q[I2C_WINDOW];
  assign i2c_in_size  = i2c_q[I2C_IN_SIZE];
  assign i2c_in_ch    = i2c_q[I2C_IN_CH];
  assign i2c_out_ch   = i2c_q[I2C_OUT_CH];
  assign i2c_out_size = i2c_q[I2C_OUT_SIZE];
  assign i2c_slide    = i2c_q[I2C_SLIDE];
  assign i2c_outcol_t = i2c_q[I2C_OUTCOL_T];
  assign i2c_incol_t  = i2c_q[I2C_INCOL_T];
  assign i2c_outrow_t = i2c_q[I2C_OUTROW_T];
  assign i2c_outch_t  = i2c_q[I2C_OUTCH_T];
  assign i2c_wrow     = i2c_q[I2C_WROW];

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] perf_cnt;

  // The copy includes the conv_last cycle itself, so a layer that ends in RUN cycle N reports N.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_cnt    <= '0;
      perf_cycles <= '0;
    end else if (state == S_START) begin
      perf_cnt <= '0;
    end else if (state == S_RUN) begin
      perf_cnt <= sat_inc(perf_cnt);
      if (conv_last && !seq_abort) perf_cycles <= sat_inc(perf_cnt);
    end
  end
`else
  assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Directed bench for conv_layer_sequencer: latency, derivation, multi-layer runs,
// error, abort, empty and saturated sequences, mid-run reset.
module tb_conv_layer_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [63:0] cfg_wdata;
  logic [4:0]  layer_count;
  logic        seq_start, seq_abort, conv_last;
  logic        busy, done, err, conv_start, conv_switch, conv_matrix2img;
  logic [3:0]  err_layer, cur_layer;
  logic [15:0] i2c_stride, i2c_kernel, i2c_window, i2c_in_size, i2c_in_ch, i2c_out_ch;
  logic [15:0] i2c_out_size, i2c_slide, i2c_outcol_t, i2c_incol_t, i2c_outrow_t;
  logic [15:0] i2c_outch_t, i2c_wrow;
  logic [31:0] perf_cycles;

  int vectors = 0;
  int miscompares = 0;
  int starts = 0;
  int dones = 0;
  int s0, d0;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (conv_start) starts++;
    if (done) dones++;
  end

  conv_layer_sequencer dut (
    .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .layer_count(layer_count), .seq_start(seq_start), .seq_abort(seq_abort), .conv_last(conv_last),
    .busy(busy), .done(done), .err(err), .err_layer(err_layer), .cur_layer(cur_layer),
    .conv_start(conv_start), .conv_switch(conv_switch), .conv_matrix2img(conv_matrix2img),
    .i2c_stride(i2c_stride), .i2c_kernel(i2c_kernel), .i2c_window(i2c_window),
    .i2c_in_size(i2c_in_size), .i2c_in_ch(i2c_in_ch), .i2c_out_ch(i2c_out_ch),
    .i2c_out_size(i2c_out_size), .i2c_slide(i2c_slide), .i2c_outcol_t(i2c_outcol_t),
    .i2c_incol_t(i2c_incol_t), .i2c_outrow_t(i2c_outrow_t), .i2c_outch_t(i2c_outch_t),
    .i2c_wrow(i2c_wrow), .perf_cycles(perf_cycles)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] mk(input int in_size, input int in_ch, input int out_ch,
                                     input int kernel, input int sl, input int win, input int m2i);
    logic [63:0] d;
    d = '0;
    d[11:0]  = 12'(in_size);
    d[23:12] = 12'(in_ch);
    d[35:24] = 12'(out_ch);
    d[40:36] = 5'(kernel);
    d[43:41] = 3'(sl);
    d[51:44] = 8'(win);
    d[52]    = 1'(m2i);
    return d;
  endfunction

  task automatic write_desc(input int addr, input logic [63:0] d);
    cfg_we = 1'b1; cfg_addr = 4'(addr); cfg_wdata = d;
    tick(1);
    cfg_we = 1'b0;
  endtask

  task automatic start_seq(input int count);
    seq_start = 1'b1; layer_count = 5'(count);
    tick(1);
    seq_start = 1'b0;
  endtask

  task automatic pulse_last();
    conv_last = 1'b1;
    tick(1);
    conv_last = 1'b0;
  endtask

  task automatic wait_conv_start(input string tag);
    int n = 0;
    while (conv_start !== 1'b1 && n < 20) begin tick(1); n++; end
    check(tag, 32'(conv_start), 1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 30) begin tick(1); n++; end
    check(tag, 32'(done), 1);
    tick(1);
  endtask

  initial begin
    reset_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; layer_count = '0;
    seq_start = 1'b0; seq_abort = 1'b0; conv_last = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(1);

    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_conv_start", 32'(conv_start), 0);
    check("rst_switch", 32'(conv_switch), 0);
    check("rst_out_size", 32'(i2c_out_size), 0);
    check("rst_perf", perf_cycles, 0);

    // Single layer {322,32,64,k3,s_log2=1,win12}: latency, derivation, perf count
    write_desc(0, mk(322, 32, 64, 3, 1, 12, 1));
    s0 = starts; d0 = dones;
    start_seq(1);
    check("t1_busy", 32'(busy), 1);
    tick(3);
    check("t1_start_early", 32'(conv_start), 0);
    tick(1);
    check("t1_start", 32'(conv_start), 1);
    check("t1_out_size", 32'(i2c_out_size), 160);
    check("t1_outcol_t", 32'(i2c_outcol_t), 20);
    check("t1_incol_t", 32'(i2c_incol_t), 1288);
    check("t1_outrow_t", 32'(i2c_outrow_t), 160);
    check("t1_outch_t", 32'(i2c_outch_t), 8);
    check("t1_wrow", 32'(i2c_wrow), 288);
    check("t1_stride", 32'(i2c_stride), 2);
    check("t1_slide", 32'(i2c_slide), 8);
    check("t1_window", 32'(i2c_window), 12);
    check("t1_kernel", 32'(i2c_kernel), 3);
    check("t1_in_ch", 32'(i2c_in_ch), 32);
    check("t1_m2i", 32'(conv_matrix2img), 1);
    check("t1_switch", 32'(conv_switch), 1);
    tick(49);
    pulse_last();
    check("t1_done_early", 32'(done), 0);
    tick(1);
    check("t1_done", 32'(done), 1);
    check("t1_done_busy", 32'(busy), 1);
    tick(1);
    check("t1_done_clr", 32'(done), 0);
    check("t1_idle_busy", 32'(busy), 0);
    check("t1_idle_out_size", 32'(i2c_out_size), 0);
    check("t1_idle_m2i", 32'(conv_matrix2img), 0);
`ifdef SEQ_PERF_CNT_EN
    check("t1_perf", perf_cycles, 50);
`else
    check("t1_perf", perf_cycles, 0);
`endif
    check("t1_starts", starts - s0, 1);
    check("t1_dones", dones - d0, 1);

    // {320,8,64,k16,s_log2=4}; conv_last before RUN ignored; writes while busy ignored
    write_desc(0, mk(320, 8, 64, 16, 4, 0, 0));
    s0 = starts; d0 = dones;
    start_seq(1);
    conv_last = 1'b1;
    tick(3);
    conv_last = 1'b0;
    tick(1);
    check("t2_start", 32'(conv_start), 1);
    check("t2_out_size", 32'(i2c_out_size), 20);
    check("t2_outcol_t", 32'(i2c_outcol_t), 3);
    check("t2_incol_t", 32'(i2c_incol_t), 320);
    check("t2_wrow", 32'(i2c_wrow), 2048);
    check("t2_stride", 32'(i2c_stride), 16);
    tick(5);
    check("t2_still_run", 32'(conv_switch), 1);
    check("t2_no_done", dones - d0, 0);
    write_desc(0, mk(322, 32, 64, 3, 1, 12, 1));
    pulse_last();
    wait_done("t2_done");
    start_seq(1);
    tick(4);
    check("t2_we_ignored", 32'(i2c_out_size), 20);
    pulse_last();
    wait_done("t2b_done");

    // Three layers, conv_last 100 cycles into each
    write_desc(0, mk(322, 32, 64, 3, 1, 12, 0));
    write_desc(1, mk(320, 8, 64, 16, 4, 0, 0));
    write_desc(2, mk(64, 16, 8, 1, 0, 0, 0));
    s0 = starts; d0 = dones;
    start_seq(3);
    for (int i = 0; i < 3; i++) begin
      wait_conv_start($sformatf("t3_start%0d", i));
      check($sformatf("t3_cur_layer%0d", i), 32'(cur_layer), i);
      check($sformatf("t3_out_size%0d", i), 32'(i2c_out_size), (i == 0) ? 160 : (i == 1) ? 20 : 64);
      tick(99);
      pulse_last();
    end
    wait_done("t3_done");
    check("t3_starts", starts - s0, 3);
    check("t3_dones", dones - d0, 1);

    // Layer 1 has in_ch=3
    write_desc(0, mk(64, 16, 8, 1, 0, 0, 0));
    write_desc(1, mk(64, 3, 8, 1, 0, 0, 0));
    s0 = starts; d0 = dones;
    start_seq(2);
    wait_conv_start("t4_start0");
    pulse_last();
    wait_done("t4_done");
    check("t4_err", 32'(err), 1);
    check("t4_err_layer", 32'(err_layer), 1);
    check("t4_starts", starts - s0, 1);
    check("t4_dones", dones - d0, 1);
    tick(2);
    check("t4_err_sticky", 32'(err), 1);

    // kernel==0 on the only layer
    write_desc(0, mk(64, 16, 8, 0, 0, 0, 0));
    s0 = starts;
    start_seq(1);
    wait_done("t5_done");
    check("t5_err", 32'(err), 1);
    check("t5_err_layer", 32'(err_layer), 0);
    check("t5_starts", starts - s0, 0);

    // Abort in RUN of layer 0
    write_desc(0, mk(322, 32, 64, 3, 1, 12, 0));
    s0 = starts; d0 = dones;
    start_seq(2);
    check("t6_err_cleared", 32'(err), 0);
    wait_conv_start("t6_start");
    tick(5);
    seq_abort = 1'b1;
    tick(1);
    seq_abort = 1'b0;
    check("t6_busy", 32'(busy), 0);
    check("t6_switch", 32'(conv_switch), 0);
    check("t6_out_size", 32'(i2c_out_size), 0);
    check("t6_err", 32'(err), 0);
    tick(3);
    pulse_last();
    tick(10);
    check("t6_busy_after", 32'(busy), 0);
    check("t6_starts", starts - s0, 1);
    check("t6_dones", dones - d0, 0);

    // layer_count == 0
    s0 = starts;
    start_seq(0);
    check("t7_done", 32'(done), 1);
    check("t7_busy", 32'(busy), 1);
    tick(1);
    check("t7_done_clr", 32'(done), 0);
    check("t7_idle", 32'(busy), 0);
    check("t7_starts", starts - s0, 0);

    // layer_count=31 saturates to 16 layers
    for (int i = 0; i < 16; i++) write_desc(i, mk(64, 16, 8, 1, 0, 0, 0));
    s0 = starts; d0 = dones;
    start_seq(31);
    for (int i = 0; i < 16; i++) begin
      wait_conv_start($sformatf("t8_start%0d", i));
      check($sformatf("t8_cur_layer%0d", i), 32'(cur_layer), i);
      tick(2);
      pulse_last();
    end
    wait_done("t8_done");
    check("t8_starts", starts - s0, 16);
    check("t8_dones", dones - d0, 1);

    // Asynchronous reset mid-run
    write_desc(0, mk(322, 32, 64, 3, 1, 12, 1));
    start_seq(1);
    wait_conv_start("t9_start");
    tick(3);
    reset_n = 1'b0;
    #1;
    check("t9_busy", 32'(busy), 0);
    check("t9_switch", 32'(conv_switch), 0);
    check("t9_out_size", 32'(i2c_out_size), 0);
    check("t9_m2i", 32'(conv_matrix2img), 0);
    tick(2);
    reset_n = 1'b1;
    tick(2);
    check("t9_idle", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
